// File: rtl/msdf_pkg.sv
// Shared types and helpers for the MSDF receive-side converter.
package msdf_pkg;

  typedef enum logic [1:0] {SKIP_S, CONV, DONE} state_t;

  function automatic int digit_width(input int radix);
    return $clog2(radix) + 1;
  endfunction

  // True for the unused -RADIX code, or for any non-zero digit seen during the skip phase.
  function automatic logic digit_bad(input int p, input int radix, input logic skip_phase);
    return (p == -radix) || (skip_phase && (p != 0));
  endfunction

endpackage

// File: rtl/msdf_otf_step.sv
// One on-the-fly conversion step: next Q/QM from the current pair and one signed digit.
module msdf_otf_step
  import msdf_pkg::*;
#(
  parameter int RADIX = 4,
  parameter int N     = 9,
  localparam int B    = $clog2(RADIX),
  localparam int D    = digit_width(RADIX)
) (
  input  logic [N-1:0]        q,
  input  logic [N-1:0]        qm,
  input  logic signed [D-1:0] p,
  output logic [N-1:0]        q_next,
  output logic [N-1:0]        qm_next
);

  logic [D-1:0] p_m1;
  logic         p_neg;
  logic         p_pos;

  assign p_m1  = p - D'(1);
  assign p_neg = p[D-1];
  assign p_pos = !p_neg && (p != '0);

  // RADIX is 2^B, so RADIX+p and RADIX-1+p share their low B bits with p and p-1.
  assign q_next  = p_neg  ? {qm[N-B-1:0], p[B-1:0]}    : {q[N-B-1:0], p[B-1:0]};
  assign qm_next = !p_pos ? {qm[N-B-1:0], p_m1[B-1:0]} : {q[N-B-1:0], p_m1[B-1:0]};

endmodule

// File: rtl/msdf_otf_conv.sv
// MSDF product-stream receiver: drops the online-delay digits and converts the rest on the fly.
// Optional digit checking is built when MSDF_OTF_CHECK_EN is defined.
module msdf_otf_conv
  import msdf_pkg::*;
#(
  parameter int RADIX = 4,
  parameter int WIDTH = 8,
  parameter int SKIP  = 3,
  localparam int B    = $clog2(RADIX),
  localparam int D    = digit_width(RADIX),
  localparam int N    = WIDTH * B + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [D-1:0] in_digit,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_value,
  output logic                out_err
);

  localparam int     CMAX  = (SKIP > WIDTH) ? SKIP : WIDTH;
  localparam int     CW    = (CMAX < 2) ? 1 : $clog2(CMAX);
  localparam state_t START = (SKIP == 0) ? CONV : SKIP_S;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  q, qm, q_next, qm_next;
  logic          accept, skip_last, word_done, handshake;

  msdf_otf_step #(.RADIX(RADIX), .N(N)) u_step (
    .q       (q),
    .qm      (qm),
    .p       (in_digit),
    .q_next  (q_next),
    .qm_next (qm_next)
  );

  assign in_ready  = (state != DONE);
  assign accept    = in_valid && in_ready;
  assign skip_last = (cnt == CW'(SKIP - 1));
  assign word_done = accept && (state == CONV) && (cnt == CW'(WIDTH - 1));
  assign handshake = (state == DONE) && out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= START;
      cnt       <= '0;
      q         <= '0;
      qm        <= '1;
      out_valid <= 1'b0;
      out_value <= '0;
    end else begin
      case (state)
        SKIP_S: if (accept) begin
          if (skip_last) begin
            cnt   <= '0;
            state <= CONV;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CONV: if (accept) begin
          if (word_done) begin
            out_value <= q_next;
            out_valid <= 1'b1;
            q         <= '0;
            qm        <= '1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            q   <= q_next;
            qm  <= qm_next;
            cnt <= cnt + CW'(1);
          end
        end
        DONE: if (handshake) begin
          out_valid <= 1'b0;
          state     <= START;
        end
        default: state <= START;
      endcase
    end
  end

`ifdef MSDF_OTF_CHECK_EN
  logic err_acc, err_reg, digit_err;

  assign digit_err = digit_bad(int'(in_digit), RADIX, state == SKIP_S);
  assign out_err   = err_reg;

  // err_acc gathers the word in flight; err_reg is the flag travelling with out_value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_acc <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      if (word_done) begin
        err_reg <= err_acc || digit_err;
        err_acc <= 1'b0;
      end else if (accept) begin
        err_acc <= err_acc || digit_err;
      end
      if (handshake) err_reg <= 1'b0;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_msdf_otf_conv.sv
// Bench for msdf_otf_conv: one SKIP=0 and one SKIP=3 instance (RADIX=4, WIDTH=4) against an arithmetic model.
module tb_msdf_otf_conv;

  localparam int RADIX = 4;
  localparam int WIDTH = 4;
  localparam int N     = 9;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        in_valid = '0;
  logic [1:0]        in_ready;
  logic signed [2:0] in_digit [2];
  logic [1:0]        out_valid;
  logic [1:0]        out_ready = 2'b11;
  logic [N-1:0]      out_value [2];
  logic [1:0]        out_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int wd [0:7];
  int wn;

  always #5 clk = ~clk;

  msdf_otf_conv #(.RADIX(RADIX), .WIDTH(WIDTH), .SKIP(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_digit(in_digit[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_value(out_value[0]), .out_err(out_err[0])
  );

  msdf_otf_conv #(.RADIX(RADIX), .WIDTH(WIDTH), .SKIP(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_digit(in_digit[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_value(out_value[1]), .out_err(out_err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: value = sum p_i * RADIX^-i, scaled by 2^(N-1) and wrapped to N bits.
  function automatic int model_value(input int skipn);
    int s = 0;
    for (int i = skipn; i < wn; i++) s = s * RADIX + wd[i];
    return s & ((1 << N) - 1);
  endfunction

  function automatic int model_err(input int skipn);
    int e = 0;
`ifdef MSDF_OTF_CHECK_EN
    for (int i = 0; i < wn; i++)
      if (wd[i] == -RADIX || (i < skipn && wd[i] != 0)) e = 1;
`endif
    return e;
  endfunction

  // Drives wd[0..wn-1] into instance u starting at a negedge; checks the result word.
  task automatic run_word(input int u, input int skipn, input bit gaps, input bit hold);
    int ev, ee;
    ev = model_value(skipn);
    ee = model_err(skipn);
    for (int k = 0; k < wn; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid[u] = 1'b0;
          @(negedge clk);
          check("gap_in_ready", 32'(in_ready[u]), 32'd1);
        end
      end
      check("in_ready", 32'(in_ready[u]), 32'd1);
      check("early_valid", 32'(out_valid[u]), 32'd0);
      in_valid[u] = 1'b1;
      in_digit[u] = 3'(wd[k]);
      @(negedge clk);
    end
    in_valid[u] = 1'b0;
    check("out_valid", 32'(out_valid[u]), 32'd1);
    check("out_value", 32'(out_value[u]), 32'(ev));
    check("out_err", 32'(out_err[u]), 32'(ee));
    check("done_ready", 32'(in_ready[u]), 32'd0);
    $display("word u=%0d digits=%0d value=%03h err=%0d exp=%03h/%0d", u, wn, out_value[u], out_err[u], ev, ee);
    if (hold) begin
      out_ready[u] = 1'b0;
      repeat (5) begin
        @(negedge clk);
        check("hold_valid", 32'(out_valid[u]), 32'd1);
        check("hold_value", 32'(out_value[u]), 32'(ev));
        check("hold_err", 32'(out_err[u]), 32'(ee));
        check("hold_ready", 32'(in_ready[u]), 32'd0);
      end
      out_ready[u] = 1'b1;
    end
    @(negedge clk);
    check("post_valid", 32'(out_valid[u]), 32'd0);
    check("post_ready", 32'(in_ready[u]), 32'd1);
  endtask

  task automatic set4(input int a, input int b, input int c, input int d);
    wd[0] = a; wd[1] = b; wd[2] = c; wd[3] = d; wn = 4;
  endtask

  task automatic set7(input int s0, input int s1, input int s2,
                      input int a, input int b, input int c, input int d);
    wd[0] = s0; wd[1] = s1; wd[2] = s2;
    wd[3] = a; wd[4] = b; wd[5] = c; wd[6] = d; wn = 7;
  endtask

  initial begin
    in_digit[0] = '0;
    in_digit[1] = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_valid", 32'(out_valid[u]), 32'd0);
      check("rst_value", 32'(out_value[u]), 32'd0);
      check("rst_err", 32'(out_err[u]), 32'd0);
      check("rst_ready", 32'(in_ready[u]), 32'd1);
    end

    // Directed words, SKIP=0
    set4(1, 2, 3, 1);     run_word(0, 0, 1'b0, 1'b0);
    set4(-1, 0, 0, 0);    run_word(0, 0, 1'b0, 1'b0);
    set4(-3, -3, -3, -3); run_word(0, 0, 1'b0, 1'b0);
    set4(1, -3, 0, 2);    run_word(0, 0, 1'b0, 1'b1);

    // SKIP=3 with gaps, then with a held output
    set7(0, 0, 0, 3, 3, 3, 3);  run_word(1, 3, 1'b1, 1'b0);
    set7(0, 0, 0, -2, 1, 0, -1); run_word(1, 3, 1'b1, 1'b1);

    // Reset in the middle of a word drops the partial result
    in_valid[0] = 1'b1;
    in_digit[0] = 3'sd3;
    @(negedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_valid", 32'(out_valid[0]), 32'd0);
    check("midrst_ready", 32'(in_ready[0]), 32'd1);
    set4(1, 2, 3, 1); run_word(0, 0, 1'b0, 1'b0);

    // Error cases (out_err expected only when checking is built)
    set7(0, 1, 0, 1, 1, 1, 1);  run_word(1, 3, 1'b0, 1'b0);
    set7(0, 0, 0, 2, 0, 1, -4); run_word(1, 3, 1'b0, 1'b0);
    set7(0, -4, 0, 1, 0, 0, 0); run_word(1, 3, 1'b1, 1'b0);
    set7(0, 0, 0, 1, 1, 1, 1);  run_word(1, 3, 1'b0, 1'b0);

    // Randomised legal words on both instances
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) wd[i] = $urandom_range(0, 6) - 3;
      wn = 4;
      run_word(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 3; i++) wd[i] = 0;
      for (int i = 3; i < 7; i++) wd[i] = $urandom_range(0, 6) - 3;
      wn = 7;
      run_word(1, 3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
